// File: rtl/flow_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : flow_gate_ctrl
//  Brief    : Gated flow-sensor pulse counter. Counts synchronized rising
//             edges of pulse_in over back-to-back windows of GATE_CYCLES
//             clocks and publishes a saturating 6-bit rate, a 5-level
//             thermometer code, an in-band alarm and an overflow flag.
//  Options  : FLOW_ALARM_PERSIST_EN - when defined, the alarm z only
//             changes after PERSIST consecutive windows agree on the band.
//  Revision : 1.0 - initial release
// ============================================================================
module flow_gate_ctrl #(
    parameter int GATE_CYCLES = 1000,
    parameter int ALARM_LO    = 20,
    parameter int ALARM_HI    = 50,
    parameter int PERSIST     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       pulse_in,
    output logic [5:0] flow_rate,
    output logic       rate_valid,
    output logic [4:0] y,
    output logic       z,
    output logic       overflow,
    output logic       busy
);

    localparam int                c_GCW       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_GCW-1:0]  c_GATE_LAST = c_GCW'(GATE_CYCLES - 1);
    localparam logic [5:0]        c_PCNT_MAX  = 6'd63;
    localparam logic [31:0]       c_ALARM_LO  = 32'(ALARM_LO);
    localparam logic [31:0]       c_ALARM_HI  = 32'(ALARM_HI);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_latch;
    logic               w_gate_last;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               w_edge;

    logic [c_GCW-1:0]   r_gate_cnt;
    logic [5:0]         r_pulse_cnt;
    logic               r_win_ovf;

    logic [31:0]        w_rate32;
    logic               w_in_band;
    logic [4:0]         w_y_nxt;
    logic               w_z_nxt;

    logic [5:0]         r_flow_rate;
    logic [4:0]         r_y;
    logic               r_z;
    logic               r_ovf;
    logic               r_rate_valid;

    // Configurations outside the supported envelope (window shorter than
    // four clocks, persistence outside the 4-bit counter range) leave this
    // marker scope in the elaborated hierarchy.
    if (GATE_CYCLES < 4 || PERSIST < 1 || PERSIST > 15) begin : g_param_out_of_range
    end

    // Two-flop synchronizer plus a third flop used only for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge      = r_sync2 & ~r_sync3;
    assign w_gate_last = (r_gate_cnt == c_GATE_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides everything, enable low aborts a window.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        w_state_nxt = ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (!enable) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_gate_last) begin
                        w_state_nxt = ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    w_latch     = 1'b1;
                    w_state_nxt = enable ? ST_GATE : ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Gate and pulse counters. An edge seen during LATCH seeds the next
    // window so nothing is lost between back-to-back windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_win_ovf   <= 1'b0;
        end else if (clear) begin
            r_gate_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_win_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_GATE: begin
                    r_gate_cnt <= w_gate_last ? '0 : r_gate_cnt + c_GCW'(1);
                    if (w_edge) begin
                        if (r_pulse_cnt == c_PCNT_MAX) begin
                            r_win_ovf <= 1'b1;
                        end else begin
                            r_pulse_cnt <= r_pulse_cnt + 6'd1;
                        end
                    end
                end
                ST_LATCH: begin
                    r_gate_cnt  <= '0;
                    r_pulse_cnt <= {5'd0, w_edge};
                    r_win_ovf   <= 1'b0;
                end
                default: begin
                    r_gate_cnt  <= '0;
                    r_pulse_cnt <= '0;
                    r_win_ovf   <= 1'b0;
                end
            endcase
        end
    end

    assign w_rate32  = {26'd0, r_pulse_cnt};
    assign w_in_band = (w_rate32 >= c_ALARM_LO) && (w_rate32 <= c_ALARM_HI);

    // Thermometer: bit k set once the count reaches 10*(k+1).
    for (genvar k = 0; k < 5; k++) begin : g_therm
        assign w_y_nxt[k] = (r_pulse_cnt >= 6'(10 * (k + 1)));
    end

`ifdef FLOW_ALARM_PERSIST_EN
    localparam logic [3:0] c_PERSIST = 4'(PERSIST);

    logic [3:0] r_in_cnt;
    logic [3:0] r_out_cnt;
    logic [3:0] w_in_inc;
    logic [3:0] w_out_inc;

    assign w_in_inc  = (r_in_cnt  == 4'hF) ? 4'hF : r_in_cnt  + 4'd1;
    assign w_out_inc = (r_out_cnt == 4'hF) ? 4'hF : r_out_cnt + 4'd1;

    // Consecutive in-band / out-of-band window runs; a band change restarts both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt  <= 4'd0;
            r_out_cnt <= 4'd0;
        end else if (clear) begin
            r_in_cnt  <= 4'd0;
            r_out_cnt <= 4'd0;
        end else if (w_latch) begin
            if (w_in_band) begin
                r_in_cnt  <= w_in_inc;
                r_out_cnt <= 4'd0;
            end else begin
                r_in_cnt  <= 4'd0;
                r_out_cnt <= w_out_inc;
            end
        end
    end

    // Alarm only flips once the current run reaches PERSIST windows.
    always_comb begin
        w_z_nxt = r_z;
        if (w_in_band && (w_in_inc >= c_PERSIST)) begin
            w_z_nxt = 1'b1;
        end else if (!w_in_band && (w_out_inc >= c_PERSIST)) begin
            w_z_nxt = 1'b0;
        end
    end
`else
    assign w_z_nxt = w_in_band;
`endif

    // Published results; they change only on the LATCH cycle (or clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flow_rate  <= 6'd0;
            r_y          <= 5'd0;
            r_z          <= 1'b0;
            r_ovf        <= 1'b0;
            r_rate_valid <= 1'b0;
        end else if (clear) begin
            r_flow_rate  <= 6'd0;
            r_y          <= 5'd0;
            r_z          <= 1'b0;
            r_ovf        <= 1'b0;
            r_rate_valid <= 1'b0;
        end else begin
            r_rate_valid <= w_latch;
            if (w_latch) begin
                r_flow_rate <= r_pulse_cnt;
                r_y         <= w_y_nxt;
                r_z         <= w_z_nxt;
                r_ovf       <= r_win_ovf;
            end
        end
    end

    assign flow_rate  = r_flow_rate;
    assign y          = r_y;
    assign z          = r_z;
    assign overflow   = r_ovf;
    assign rate_valid = r_rate_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
